axi_burst_loader: RTL and testbench



---
 rtl/axi_pkg.sv | 25 ++
 rtl/byte_packer64.sv | 61 ++++++
 rtl/axi_burst_loader.sv | 187 ++++++++++++++++++
 tb/tb_axi_burst_loader.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and loader FSM state type for the boot-image loader.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        FILL,
        AW,
        W,
        B,
        DONE
    } ldr_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] s);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, s[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/byte_packer64.sv
// Packs a byte stream little-endian into 64-bit words with per-lane strobes.
module byte_packer64
    import axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    input  logic        i_flush,
    output logic        o_push,
    output logic [63:0] o_word,
    output logic [7:0]  o_strb,
    output logic        o_empty
);

    logic [63:0] word_q, word_d;
    logic [7:0]  strb_q, strb_d;
    logic [2:0]  idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        strb_d = strb_q;
        idx_d  = idx_q;
        o_push = 1'b0;
        o_word = word_q;
        o_strb = strb_q;
        if (i_accept) begin
            word_d[{idx_q, 3'b000} +: 8] = i_data;
            strb_d[idx_q]                = 1'b1;
            idx_d                        = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                o_push = 1'b1;
                o_word = word_d;
                o_strb = strb_d;
                word_d = '0;
                strb_d = '0;
            end
        end else if (i_flush && (idx_q != 3'd0)) begin
            // unused lanes are still zero from the last clear
            o_push = 1'b1;
            word_d = '0;
            strb_d = '0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            strb_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            strb_q <= strb_d;
            idx_q  <= idx_d;
        end
    end

    assign o_empty = (idx_q == 3'd0);

endmodule

// File: rtl/axi_burst_loader.sv
// Streams boot bytes into one-burst buffer and writes them out as AXI4 INCR bursts.
// state | meaning
// FILL  | accepting bytes into packer/buffer
// AW    | presenting write address for buffered words
// W     | sending buffered beats
// B     | waiting for write response, then commit
// DONE  | flush complete, parked until reset
module axi_burst_loader
    import axi_pkg::*;
#(
    parameter int          ID_WIDTH  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          BURST_LEN = 16,
    parameter int          AWID      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_data,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_flush,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic                o_done,
    output logic                o_err,
    output logic [31:0]         o_count
);

    localparam int IDXW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNTW = $clog2(BURST_LEN + 1);
    localparam int BYTW = $clog2(BURST_LEN * 8 + 1);

    ldr_state_e      state_q, state_d;
    logic [CNTW-1:0] words_q, words_d;
    logic [IDXW-1:0] beat_q, beat_d;
    logic [BYTW-1:0] bytes_q, bytes_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     count_q, count_d;
    logic            err_q, err_d;
    logic            flush_q, flush_d;
    logic            ready_en_q;

    logic [63:0]     buf_data [BURST_LEN];
    logic [7:0]      buf_strb [BURST_LEN];

    logic            accept;
    logic            pk_flush;
    logic            pk_push;
    logic [63:0]     pk_word;
    logic [7:0]      pk_strb;
    logic            pk_empty;
    logic            wlast;
    logic            unused_bid;

    // stop taking bytes once a flush is pending so the packer drains cleanly
    assign o_ready  = ready_en_q && (state_q == FILL) && !flush_q;
    assign accept   = i_valid && o_ready;
    assign pk_flush = (state_q == FILL) && flush_q;

    byte_packer64 u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_accept (accept),
        .i_data   (i_data),
        .i_flush  (pk_flush),
        .o_push   (pk_push),
        .o_word   (pk_word),
        .o_strb   (pk_strb),
        .o_empty  (pk_empty)
    );

    always_ff @(posedge clk) begin
        if (pk_push) begin
            buf_data[words_q[IDXW-1:0]] <= pk_word;
            buf_strb[words_q[IDXW-1:0]] <= pk_strb;
        end
    end

    assign wlast = (state_q == W) && (beat_q == IDXW'(words_q - CNTW'(1)));

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        beat_d  = beat_q;
        bytes_d = bytes_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        flush_d = flush_q | i_flush;
        case (state_q)
            FILL: begin
                if (pk_push) begin
                    words_d = words_q + CNTW'(1);
                    bytes_d = bytes_q + BYTW'(popcount8(pk_strb));
                end
                if (pk_push && (words_q == CNTW'(BURST_LEN - 1))) begin
                    state_d = AW;
                end else if (flush_q && pk_empty) begin
                    state_d = (words_q == '0) ? DONE : AW;
                end
            end
            AW: begin
                if (i_awready) begin
                    state_d = W;
                    beat_d  = '0;
                end
            end
            W: begin
                if (i_wready) begin
                    if (wlast) begin
                        state_d = B;
                    end else begin
                        beat_d = beat_q + IDXW'(1);
                    end
                end
            end
            B: begin
                if (i_bvalid) begin
                    err_d   = err_q | (i_bresp != AXI_RESP_OKAY);
                    count_d = count_q + 32'(bytes_q);
                    addr_d  = addr_q + (32'(words_q) << 3);
                    words_d = '0;
                    bytes_d = '0;
                    state_d = flush_d ? DONE : FILL;
                end
            end
            DONE: begin
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            words_q    <= '0;
            beat_q     <= '0;
            bytes_q    <= '0;
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            flush_q    <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            beat_q     <= beat_d;
            bytes_q    <= bytes_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            flush_q    <= flush_d;
            ready_en_q <= 1'b1;
        end
    end

    assign o_awid     = ID_WIDTH'(AWID);
    assign o_awaddr   = addr_q;
    assign o_awlen    = 8'(words_q - CNTW'(1));
    assign o_awsize   = AXI_SIZE_8B;
    assign o_awburst  = AXI_BURST_INCR;
    assign o_awvalid  = (state_q == AW);
    assign o_wdata    = buf_data[beat_q];
    assign o_wstrb    = buf_strb[beat_q];
    assign o_wlast    = wlast;
    assign o_wvalid   = (state_q == W);
    assign o_bready   = (state_q == B);
    assign o_done     = (state_q == DONE);
    assign o_err      = err_q;
    assign o_count    = count_q;
    assign unused_bid = ^i_bid;

endmodule

// File: tb/tb_axi_burst_loader.sv
// Scoreboard bench for axi_burst_loader: byte-list reference model, random AXI stalls.
module tb_axi_burst_loader;

    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_flush = 1'b0;
    logic [0:0]  o_awid;
    logic [31:0] o_awaddr;
    logic [7:0]  o_awlen;
    logic [2:0]  o_awsize;
    logic [1:0]  o_awburst;
    logic        o_awvalid;
    logic        i_awready = 1'b0;
    logic [63:0] o_wdata;
    logic [7:0]  o_wstrb;
    logic        o_wlast;
    logic        o_wvalid;
    logic        i_wready = 1'b0;
    logic [0:0]  i_bid = '0;
    logic [1:0]  i_bresp = 2'b00;
    logic        i_bvalid = 1'b0;
    logic        o_bready;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_count;

    always #5 clk = ~clk;

    axi_burst_loader #(
        .ID_WIDTH  (1),
        .BASE_ADDR (32'h0000_0000),
        .BURST_LEN (BL),
        .AWID      (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_flush   (i_flush),
        .o_awid    (o_awid),
        .o_awaddr  (o_awaddr),
        .o_awlen   (o_awlen),
        .o_awsize  (o_awsize),
        .o_awburst (o_awburst),
        .o_awvalid (o_awvalid),
        .i_awready (i_awready),
        .o_wdata   (o_wdata),
        .o_wstrb   (o_wstrb),
        .o_wlast   (o_wlast),
        .o_wvalid  (o_wvalid),
        .i_wready  (i_wready),
        .i_bid     (i_bid),
        .i_bresp   (i_bresp),
        .i_bvalid  (i_bvalid),
        .o_bready  (o_bready),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_count   (o_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_exp_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_exp_t;

    aw_exp_t     exp_aw_q[$];
    w_exp_t      exp_w_q[$];
    int          exp_bytes_q[$];
    logic [7:0]  pend_q[$];
    logic [31:0] m_addr = '0;
    int          m_total = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          stall_en = 1'b0;
    bit          err_first = 1'b0;
    int          b_seen = 0;
    int          w_hs = 0;
    int          committed = 0;
    bit          aw_open = 1'b0;
    logic [7:0]  mem [int];
    logic [31:0] cur_baddr = '0;
    int          cur_beat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: a burst is simply the next run of pending bytes, 8 per word.
    function automatic void model_emit();
        int      n;
        int      words;
        aw_exp_t a;
        w_exp_t  w;
        n      = pend_q.size();
        words  = (n + 7) / 8;
        a.addr = m_addr;
        a.len  = 8'(words - 1);
        exp_aw_q.push_back(a);
        for (int i = 0; i < words; i++) begin
            w.data = '0;
            w.strb = '0;
            for (int l = 0; l < 8; l++) begin
                if (i * 8 + l < n) begin
                    w.data[l*8 +: 8] = pend_q[i*8 + l];
                    w.strb[l]        = 1'b1;
                end
            end
            w.last = (i == words - 1);
            exp_w_q.push_back(w);
        end
        exp_bytes_q.push_back(n);
        m_total += n;
        m_addr  += 32'(words * 8);
        pend_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        pend_q.push_back(b);
        if (pend_q.size() == BL * 8) model_emit();
    endfunction

    function automatic void model_flush();
        if (pend_q.size() > 0) model_emit();
    endfunction

    function automatic void model_reset();
        exp_aw_q.delete();
        exp_w_q.delete();
        exp_bytes_q.delete();
        pend_q.delete();
        mem.delete();
        m_addr    = '0;
        m_total   = 0;
        committed = 0;
        b_seen    = 0;
        w_hs      = 0;
    endfunction

    // Slave side: random readies, B only while the loader is waiting for it.
    always @(posedge clk) begin
        #1;
        i_awready = stall_en ? ($urandom % 3 != 0) : 1'b1;
        i_wready  = stall_en ? ($urandom % 3 != 0) : 1'b1;
        i_bvalid  = o_bready && (stall_en ? ($urandom % 2 != 0) : 1'b1);
        i_bresp   = (err_first && b_seen == 0) ? 2'b10 : 2'b00;
    end

    logic        aw_hold = 1'b0;
    logic        w_hold = 1'b0;
    logic [39:0] aw_prev = '0;
    logic [63:0] wd_prev = '0;
    logic [8:0]  wc_prev = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_hold = 1'b0;
            w_hold  = 1'b0;
            aw_open = 1'b0;
        end else begin
            if (aw_hold) chk("aw_stable", 64'({o_awvalid, o_awaddr, o_awlen}), 64'({1'b1, aw_prev}));
            if (w_hold) begin
                chk("w_data_stable", o_wdata, wd_prev);
                chk("w_ctrl_stable", 64'({o_wvalid, o_wstrb, o_wlast}), 64'({1'b1, wc_prev}));
            end
            if (o_wvalid) chk("w_after_aw", 64'(aw_open), 64'd1);
            if (o_awvalid && i_awready) begin
                if (exp_aw_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL aw_unexpected: got AW addr %h, want none", o_awaddr);
                end else begin
                    aw_exp_t a;
                    a = exp_aw_q.pop_front();
                    chk("aw_addr", 64'(o_awaddr), 64'(a.addr));
                    chk("aw_len", 64'(o_awlen), 64'(a.len));
                    chk("aw_size_burst_id", 64'({o_awsize, o_awburst, o_awid}), 64'({3'd3, 2'b01, 1'b0}));
                    chk("count_at_aw", 64'(o_count), 64'(committed));
                    chk("err_at_aw", 64'(o_err), 64'(err_first && b_seen > 0));
                end
                aw_open   = 1'b1;
                cur_baddr = o_awaddr;
                cur_beat  = 0;
            end
            if (o_wvalid && i_wready) begin
                if (exp_w_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL w_unexpected: got beat data %h, want none", o_wdata);
                end else begin
                    w_exp_t w;
                    w = exp_w_q.pop_front();
                    chk("w_data", o_wdata, w.data);
                    chk("w_strb", 64'(o_wstrb), 64'(w.strb));
                    chk("w_last", 64'(o_wlast), 64'(w.last));
                end
                for (int l = 0; l < 8; l++) begin
                    if (o_wstrb[l]) mem[int'(cur_baddr) + cur_beat * 8 + l] = o_wdata[l*8 +: 8];
                end
                cur_beat++;
                w_hs++;
                if (o_wlast) aw_open = 1'b0;
            end
            if (o_bready && i_bvalid) begin
                b_seen++;
                if (exp_bytes_q.size() > 0) committed += exp_bytes_q.pop_front();
            end
            aw_hold = o_awvalid && !i_awready;
            aw_prev = {o_awaddr, o_awlen};
            w_hold  = o_wvalid && !i_wready;
            wd_prev = o_wdata;
            wc_prev = {o_wstrb, o_wlast};
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fl);
        int t;
        bit acc;
        t       = 0;
        acc     = 1'b0;
        i_valid = 1'b1;
        i_data  = b;
        i_flush = fl;
        model_byte(b);
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            i_flush = 1'b0;
            t++;
        end
        i_valid = 1'b0;
        chk("byte_accepted", 64'(acc), 64'd1);
    endtask

    task automatic send_flush();
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        model_flush();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!o_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done", 64'(o_done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input bit exp_err);
        chk("aw_drained", 64'(exp_aw_q.size()), 64'd0);
        chk("w_drained", 64'(exp_w_q.size()), 64'd0);
        chk("count", 64'(o_count), 64'(m_total));
        chk("err", 64'(o_err), 64'(exp_err));
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({o_ready, o_awvalid, o_wvalid, o_bready, o_done, o_err, o_count}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] stream[$];
        logic [7:0] b;
        int         n;
        int         bad;
        int         t;

        // full burst of an incrementing pattern, no stalls
        do_reset();
        stall_en = 1'b0;
        for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b0);
        chk("awvalid_after_fill", 64'(o_awvalid), 64'd1);
        send_flush();
        wait_done();
        end_checks(1'b0);

        // partial flush, the last byte arrives with the flush pulse
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i), 1'b0);
        send_byte(8'hAA, 1'b1);
        model_flush();
        wait_done();
        end_checks(1'b0);

        // two bursts with random stalls on both sides, memory readback
        do_reset();
        stall_en = 1'b1;
        stream.delete();
        for (int i = 0; i < 256; i++) begin
            idle($urandom_range(0, 2));
            b = 8'($urandom);
            stream.push_back(b);
            send_byte(b, 1'b0);
        end
        send_flush();
        wait_done();
        end_checks(1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (!mem.exists(i)) bad++;
            else if (mem[i] !== stream[i]) bad++;
        end
        chk("readback_mismatches", 64'(bad), 64'd0);

        // error response on the first burst, loading carries on
        do_reset();
        err_first = 1'b1;
        n = 256 + $urandom_range(1, 40);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 1));
            send_byte(8'($urandom), 1'b0);
        end
        send_flush();
        wait_done();
        end_checks(1'b1);
        err_first = 1'b0;
        stall_en  = 1'b0;

        // empty flush straight after reset
        do_reset();
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        model_flush();
        t = 0;
        while (!o_done && t < 2) begin
            @(negedge clk);
            t++;
        end
        chk("empty_flush_done", 64'(o_done), 64'd1);
        @(posedge clk);
        #1;
        end_checks(1'b0);

        // reset in the middle of the W phase, then a fresh load from BASE_ADDR
        do_reset();
        for (int i = 0; i < 128; i++) send_byte(8'($urandom), 1'b0);
        t = 0;
        while (w_hs < 6 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("reached_beat5", 64'(w_hs >= 6), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({o_ready, o_awvalid, o_wvalid, o_bready, o_done, o_err, o_count}), 64'd0);
        do_reset();
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0);
        send_flush();
        wait_done();
        end_checks(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
